// File: rtl/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Shares one synchronous tb_memory between two requesters: port A
// (instruction fetch) and port B (data load/store). Each cycle the eligible
// requests are arbitrated, the winner's access is registered onto the memory
// pins, and two cycles after the grant the read data (or write completion) is
// handed back to the port that issued it. One new access can be accepted
// every cycle; up to three are in flight, completing in grant order.
//
// Parameters
//   fixed_prio  0: round-robin between A and B on a tie; 1: A always wins a tie
//   first_port  round-robin pointer after reset (0: A wins first tie, 1: B)
//
// Ports
//   clk        in   memory clock, all logic on posedge
//   reset      in   asynchronous, active-low reset
//   a_req      in   A access request, held with its fields until a_gnt
//   a_addr     in   A byte address [15:0]
//   a_wdata    in   A write data [15:0] (8-bit writes use [7:0])
//   a_sz       in   A access size (0: 8-bit, 1: 16-bit)
//   a_we       in   A write enable (1: write, 0: read)
//   a_gnt      out  one-cycle pulse, A access accepted
//   a_done     out  one-cycle pulse, A access completed (2 cycles after a_gnt)
//   a_rdata    out  A read data, valid from a_done, held until next A read
//   b_*             same set for port B
//   mem_addr   out  to tb_memory addr_in
//   mem_wdata  out  to tb_memory write_data_in
//   mem_sz     out  to tb_memory data_acc_sz
//   mem_we     out  to tb_memory write_data_we
//   mem_rdata  in   from tb_memory read_data_out (registered in the memory)
// -----------------------------------------------------------------------------
module tb_mem_arbiter #(
  parameter logic fixed_prio = 1'b0,
  parameter logic first_port = 1'b0
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        a_req,
  input  logic [15:0] a_addr,
  input  logic [15:0] a_wdata,
  input  logic        a_sz,
  input  logic        a_we,
  output logic        a_gnt,
  output logic        a_done,
  output logic [15:0] a_rdata,

  input  logic        b_req,
  input  logic [15:0] b_addr,
  input  logic [15:0] b_wdata,
  input  logic        b_sz,
  input  logic        b_we,
  output logic        b_gnt,
  output logic        b_done,
  output logic [15:0] b_rdata,

  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_sz,
  output logic        mem_we,
  input  logic [15:0] mem_rdata
);

  // Arbitration
  logic a_elig;
  logic b_elig;
  logic win_a;
  logic win_b;
  logic tie_flip;
  logic rr_ptr;     // 0: A wins the next tie, 1: B wins it

  // Owner/we tag pipeline: bit 0 = grant cycle N, bit 1 = N+1, bit 2 = N+2
  logic [2:0] tag_vld;
  logic [2:0] tag_own;  // 0: A, 1: B
  logic [2:0] tag_we;

  // A request is ignored in the cycle its own grant pulses, so a requester
  // holding req high continuously is served on alternate cycles.
  assign a_elig = a_req & ~a_gnt;
  assign b_elig = b_req & ~b_gnt;

  always_comb begin
    win_a    = 1'b0;
    win_b    = 1'b0;
    tie_flip = 1'b0;
    if (a_elig && b_elig) begin
      if (fixed_prio || !rr_ptr) begin
        win_a = 1'b1;
      end else begin
        win_b = 1'b1;
      end
      // The pointer only moves on a genuine two-way tie, towards the loser.
      tie_flip = ~fixed_prio;
    end else begin
      win_a = a_elig;
      win_b = b_elig;
    end
  end

  // Grant pulses, round-robin pointer and the registered memory pins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_gnt     <= 1'b0;
      b_gnt     <= 1'b0;
      rr_ptr    <= first_port;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_sz    <= 1'b0;
      mem_we    <= 1'b0;
    end else begin
      a_gnt <= win_a;
      b_gnt <= win_b;
      if (tie_flip) begin
        rr_ptr <= ~rr_ptr;
      end
      if (win_a) begin
        mem_addr  <= a_addr;
        mem_wdata <= a_wdata;
        mem_sz    <= a_sz;
        mem_we    <= a_we;
      end else if (win_b) begin
        mem_addr  <= b_addr;
        mem_wdata <= b_wdata;
        mem_sz    <= b_sz;
        mem_we    <= b_we;
      end else begin
        // Idle cycle: address/data/size hold, so the memory performs a
        // harmless read of the last location.
        mem_we <= 1'b0;
      end
    end
  end

  // Tag shift register following each access through N, N+1 and N+2
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_vld <= '0;
      tag_own <= '0;
      tag_we  <= '0;
    end else begin
      tag_vld <= {tag_vld[1:0], win_a | win_b};
      tag_own <= {tag_own[1:0], win_b};
      tag_we  <= {tag_we[1:0], win_a ? a_we : (win_b & b_we)};
    end
  end

  // mem_rdata is valid during N+1; capture it at the end of that cycle so the
  // owner sees it together with its done pulse in N+2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else if (tag_vld[1] && !tag_we[1]) begin
      if (tag_own[1]) begin
        b_rdata <= mem_rdata;
      end else begin
        a_rdata <= mem_rdata;
      end
    end
  end

  // Only one tag occupies stage N+2, so the two done pulses are exclusive.
  assign a_done = tag_vld[2] & ~tag_own[2];
  assign b_done = tag_vld[2] &  tag_own[2];

endmodule

// File: tb/tb_tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tb_mem_arbiter
//
// Bench for tb_mem_arbiter. A byte-wide memory stub stands in for tb_memory
// (registered read, 8-bit reads zero-extended, 16-bit little-endian with
// address wrap). Expected completions are queued when an access is granted
// and retired when the matching done pulse appears. A second instance with
// fixed priority shares the requester inputs and is checked for grants only.
// -----------------------------------------------------------------------------
module tb_tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;

  logic        a_req, a_sz, a_we;
  logic [15:0] a_addr, a_wdata;
  logic        b_req, b_sz, b_we;
  logic [15:0] b_addr, b_wdata;

  logic        a_gnt, a_done, b_gnt, b_done;
  logic [15:0] a_rdata, b_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_sz, mem_we;

  logic        f_a_gnt, f_a_done, f_b_gnt, f_b_done;
  logic [15:0] f_a_rdata, f_b_rdata;
  logic [15:0] f_mem_addr, f_mem_wdata;
  logic        f_mem_sz, f_mem_we;
  logic [15:0] f_mem_rdata = 16'h0000;

  int compared = 0;
  int mism     = 0;
  int cyc      = 0;
  int we_count = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  tb_mem_arbiter #(.fixed_prio(1'b0), .first_port(1'b0)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_addr(a_addr), .a_wdata(a_wdata), .a_sz(a_sz), .a_we(a_we),
    .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_addr(b_addr), .b_wdata(b_wdata), .b_sz(b_sz), .b_we(b_we),
    .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_sz(mem_sz), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  tb_mem_arbiter #(.fixed_prio(1'b1), .first_port(1'b0)) dut_fix (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_addr(a_addr), .a_wdata(a_wdata), .a_sz(a_sz), .a_we(a_we),
    .a_gnt(f_a_gnt), .a_done(f_a_done), .a_rdata(f_a_rdata),
    .b_req(b_req), .b_addr(b_addr), .b_wdata(b_wdata), .b_sz(b_sz), .b_we(b_we),
    .b_gnt(f_b_gnt), .b_done(f_b_done), .b_rdata(f_b_rdata),
    .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata), .mem_sz(f_mem_sz), .mem_we(f_mem_we),
    .mem_rdata(f_mem_rdata)
  );

  function automatic logic [7:0] pat(input int i);
    logic [15:0] v;
    v = i[15:0];
    return v[7:0] ^ v[15:8];
  endfunction

  // ---------------- memory stub ----------------
  logic [7:0]  mem [0:65535];
  logic        mem_loaded = 1'b0;
  logic [15:0] mem_addr1;
  assign mem_addr1 = mem_addr + 16'd1;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 65536; i++) mem[i] <= pat(i);
      mem[0]     <= 8'h34;
      mem[1]     <= 8'h12;
      mem_loaded <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata[7:0];
      if (mem_sz) mem[mem_addr1] <= mem_wdata[15:8];
    end
    mem_rdata <= mem_sz ? {mem[mem_addr1], mem[mem_addr]} : {8'h00, mem[mem_addr]};
  end

  // ---------------- expected memory contents ----------------
  logic [7:0] shadow [0:65535];

  function automatic logic [15:0] sh_read(input logic [15:0] addr, input logic sz);
    logic [15:0] a1;
    a1 = addr + 16'd1;
    return sz ? {shadow[a1], shadow[addr]} : {8'h00, shadow[addr]};
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic        port;   // 0: A, 1: B
    logic        we;
    logic [15:0] rdata;
    int          gcyc;
  } sb_t;

  sb_t  sbq[$];
  logic gnt_log[$];
  logic [15:0] hold_a = 16'h0000;
  logic [15:0] hold_b = 16'h0000;

  task automatic push(input logic port, input logic [15:0] addr, input logic [15:0] wdata,
                      input logic sz, input logic we);
    sb_t e;
    e.port  = port;
    e.we    = we;
    e.gcyc  = cyc;
    e.rdata = 16'h0000;
    if (we) begin
      shadow[addr] = wdata[7:0];
      if (sz) shadow[addr + 16'd1] = wdata[15:8];
    end else begin
      e.rdata = sh_read(addr, sz);
    end
    sbq.push_back(e);
    gnt_log.push_back(port);
  endtask

  // Reference arbiters (round-robin and fixed priority) driven by the same inputs
  logic m_ag, m_bg, m_ptr, fm_ag, fm_bg;
  logic m_ea, m_eb, fm_ea, fm_eb;
  assign m_ea  = a_req & ~m_ag;
  assign m_eb  = b_req & ~m_bg;
  assign fm_ea = a_req & ~fm_ag;
  assign fm_eb = b_req & ~fm_bg;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ag <= 1'b0; m_bg <= 1'b0; m_ptr <= 1'b0;
      fm_ag <= 1'b0; fm_bg <= 1'b0;
    end else begin
      if (m_ea && m_eb) begin
        m_ag  <= ~m_ptr;
        m_bg  <= m_ptr;
        m_ptr <= ~m_ptr;
      end else begin
        m_ag <= m_ea;
        m_bg <= m_eb;
      end
      fm_ag <= fm_ea;
      fm_bg <= fm_eb & ~fm_ea;
    end
  end

  // Completion monitor
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("rr_a_gnt", {31'd0, a_gnt}, {31'd0, m_ag});
      chk("rr_b_gnt", {31'd0, b_gnt}, {31'd0, m_bg});
      chk("fix_a_gnt", {31'd0, f_a_gnt}, {31'd0, fm_ag});
      chk("fix_b_gnt", {31'd0, f_b_gnt}, {31'd0, fm_bg});
      chk("fix_done_excl", {31'd0, f_a_done & f_b_done}, 32'd0);
      if (mem_we) we_count++;
      if (a_done || b_done) begin
        chk("done_excl", {31'd0, a_done & b_done}, 32'd0);
        compared++;
        assert (sbq.size() != 0) else begin
          mism++;
          $error("FAIL spurious_done: observed done a=%0b b=%0b with nothing outstanding, expected no done",
                 a_done, b_done);
        end
        if (sbq.size() != 0) begin
          sb_t e;
          e = sbq.pop_front();
          chk("done_port", {31'd0, b_done}, {31'd0, e.port});
          chk("gnt_to_done", cyc - e.gcyc, 32'd2);
          if (!e.we) begin
            if (e.port) hold_b = e.rdata;
            else        hold_a = e.rdata;
          end
          chk("a_rdata", {16'd0, a_rdata}, {16'd0, hold_a});
          chk("b_rdata", {16'd0, b_rdata}, {16'd0, hold_b});
        end
      end
    end
  end

  // ---------------- requester drivers ----------------
  task automatic acc_a(input logic [15:0] addr, input logic [15:0] wdata,
                       input logic sz, input logic we, output int waited);
    waited = 0;
    a_req = 1'b1; a_addr = addr; a_wdata = wdata; a_sz = sz; a_we = we;
    do begin
      @(negedge clk);
      waited++;
    end while (!a_gnt && waited < 40);
    compared++;
    assert (a_gnt) else begin
      mism++;
      $error("FAIL a_gnt_timeout: observed no a_gnt in %0d cycles, expected a grant", waited);
    end
    if (a_gnt) push(1'b0, addr, wdata, sz, we);
    a_req = 1'b0;
  endtask

  task automatic acc_b(input logic [15:0] addr, input logic [15:0] wdata,
                       input logic sz, input logic we, output int waited);
    waited = 0;
    b_req = 1'b1; b_addr = addr; b_wdata = wdata; b_sz = sz; b_we = we;
    do begin
      @(negedge clk);
      waited++;
    end while (!b_gnt && waited < 40);
    compared++;
    assert (b_gnt) else begin
      mism++;
      $error("FAIL b_gnt_timeout: observed no b_gnt in %0d cycles, expected a grant", waited);
    end
    if (b_gnt) push(1'b1, addr, wdata, sz, we);
    b_req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("drain_outstanding", sbq.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_gnt"},   {30'd0, a_gnt, b_gnt}, 32'd0);
    chk({tag, "_done"},  {30'd0, a_done, b_done}, 32'd0);
    chk({tag, "_rdata"}, {a_rdata, b_rdata}, 32'd0);
    chk({tag, "_maddr"}, {mem_addr, mem_wdata}, 32'd0);
    chk({tag, "_msz_we"}, {30'd0, mem_sz, mem_we}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int w, w2, gl0, n;
    reset = 1'b0;
    a_req = 1'b0; a_addr = '0; a_wdata = '0; a_sz = 1'b0; a_we = 1'b0;
    b_req = 1'b0; b_addr = '0; b_wdata = '0; b_sz = 1'b0; b_we = 1'b0;
    for (int i = 0; i < 65536; i++) shadow[i] = pat(i);
    shadow[0] = 8'h34;
    shadow[1] = 8'h12;

    #7;
    chk_reset_values("por");
    @(negedge clk);
    reset = 1'b1;

    // 16-bit read of address 0 holding 0x1234
    acc_a(16'h0000, 16'h0000, 1'b1, 1'b0, w);
    chk("t1_gnt_latency", w, 32'd1);
    drain();

    // Both ports request back to back
    fork
      for (int i = 0; i < 6; i++) acc_a(16'h0100 + 16'(2 * i), 16'h0000, 1'b1, 1'b0, w);
      for (int j = 0; j < 6; j++) acc_b(16'h0200 + 16'(3 * j), 16'h0000, j[0], 1'b0, w2);
    join
    drain();

    // Two isolated ties: round-robin pointer now favours B, then A
    gl0 = gnt_log.size();
    fork
      acc_a(16'h0300, 16'h0000, 1'b0, 1'b0, w);
      acc_b(16'h0301, 16'h0000, 1'b0, 1'b0, w2);
    join
    @(negedge clk);
    fork
      acc_a(16'h0302, 16'h0000, 1'b1, 1'b0, w);
      acc_b(16'h0304, 16'h0000, 1'b1, 1'b0, w2);
    join
    chk("tie_grants", gnt_log.size() - gl0, 32'd4);
    if (gnt_log.size() >= gl0 + 4) begin
      chk("tie1_first",  {31'd0, gnt_log[gl0]},     32'd1);
      chk("tie1_second", {31'd0, gnt_log[gl0 + 1]}, 32'd0);
      chk("tie2_first",  {31'd0, gnt_log[gl0 + 2]}, 32'd0);
      chk("tie2_second", {31'd0, gnt_log[gl0 + 3]}, 32'd1);
    end
    drain();

    // B byte write then A byte read of the same address a cycle later
    fork
      acc_b(16'h0101, 16'h00AB, 1'b0, 1'b1, w2);
      begin
        @(negedge clk);
        acc_a(16'h0101, 16'h0000, 1'b0, 1'b0, w);
      end
    join
    drain();

    // 16-bit write/read at the top of the address space
    we_count = 0;
    acc_a(16'hfffe, 16'hBEEF, 1'b1, 1'b1, w);
    acc_a(16'hfffe, 16'h0000, 1'b1, 1'b0, w);
    drain();
    chk("top_rdata", {16'd0, a_rdata}, 32'h0000BEEF);
    chk("top_we_cycles", we_count, 32'd1);

    // Reset with three accesses in flight, the newest a write
    fork
      begin
        acc_a(16'h0010, 16'h0000, 1'b1, 1'b0, w);
        a_req = 1'b1; a_addr = 16'h0030; a_wdata = 16'hC3C3; a_sz = 1'b1; a_we = 1'b1;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!a_gnt && n < 10);
        chk("rst_write_gnt", {31'd0, a_gnt}, 32'd1);
      end
      begin
        @(negedge clk);
        acc_b(16'h0020, 16'h0000, 1'b1, 1'b0, w2);
      end
    join
    #2;
    reset = 1'b0;
    #1;
    chk_reset_values("rst");
    sbq.delete();
    hold_a = 16'h0000;
    hold_b = 16'h0000;
    a_req = 1'b0; a_we = 1'b0;
    b_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    chk_reset_values("post_rst");

    // The write caught by reset must not have reached the memory
    acc_a(16'h0030, 16'h0000, 1'b1, 1'b0, w);
    drain();
    chk("dropped_write", {16'd0, a_rdata}, {16'd0, pat(16'h0031), pat(16'h0030)});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
